// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM encoding, default sizes and index-width helper for the multiword CLA sequencer.
package cla_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
    localparam int DEF_SLICE_W = 16;
    localparam int DEF_NUM_SLICES = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/carry_look_ahead.sv
// carry_look_ahead: N-bit combinational adder built from generate/propagate terms.
module carry_look_ahead #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] g, p;
    logic c;
    assign g = a & b;
    assign p = a ^ b;
    always_comb begin
        c = cin;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = p[i] ^ c;
            c = g[i] | (p[i] & c);
        end
        cout = c;
    end
endmodule

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: wide add sequenced one slice per cycle through an external CLA slice adder.
module cla_multiword_seq
    import cla_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
    input  logic                          op_cin,
    output logic [SLICE_W-1:0]            cla_a,
    output logic [SLICE_W-1:0]            cla_b,
    output logic                          cla_cin,
    input  logic [SLICE_W-1:0]            cla_sum,
    input  logic                          cla_cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] result,
    output logic                          result_cout,
    output logic                          overflow
);
    localparam int W = SLICE_W * NUM_SLICES;
    localparam int IW = idx_w(NUM_SLICES);
    state_e state_q, state_d;
    logic [IW-1:0] idx_q;
    logic carry_q, rcout_q, ovf_q;
    logic [W-1:0] a_q, b_q, res_q;
    logic run, last;
    assign run = state_q == RUN;
    assign last = idx_q == IW'(NUM_SLICES - 1);
    assign in_ready = (state_q == IDLE) && !rst;
    assign out_valid = state_q == DONE;
    assign cla_a = run ? a_q[int'(idx_q)*SLICE_W +: SLICE_W] : '0;
    assign cla_b = run ? b_q[int'(idx_q)*SLICE_W +: SLICE_W] : '0;
    assign cla_cin = run & carry_q;
    assign result = res_q;
    assign result_cout = rcout_q;
    assign overflow = ovf_q;
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE && in_valid) ? RUN :
                  (state_q == RUN && last) ? DONE :
                  (state_q == DONE && out_ready) ? IDLE : state_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            carry_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            rcout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_q <= op_a;
                b_q <= op_b;
                carry_q <= op_cin;
                idx_q <= '0;
            end
            if (run) begin
                res_q[int'(idx_q)*SLICE_W +: SLICE_W] <= cla_sum;
                carry_q <= cla_cout;
                // idx saturates on the last slice so it never leaves the valid range
                if (last) begin
                    rcout_q <= cla_cout;
                    ovf_q <= (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE_W-1] != a_q[W-1]);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end
endmodule
